cpu_clk_ctrl: RTL
=================

Name: cpu_clk_ctrl

Overview:
Parametrised CPU clock-enable controller for the board top level; it replaces the muxed, gated CPU clock with a single-cycle enable pulse `cpu_ce` on the board clock.
- Modes: manual step, two programmable slow rates, full speed.
- Adds an address breakpoint with halt/resume, a built-in button synchroniser and debouncer, and an issued-cycle counter for the display.
- The CPU core runs on `clk` and qualifies every register update with `cpu_ce`.

Parameters:
ADDR_W, 12, width of `pc_addr` and `brk_addr`
SLOW_DIV, 50_000_000, board cycles per `cpu_ce` in slow mode (≥1)
MED_DIV, 5_000_000, board cycles per `cpu_ce` in medium mode (≥1)
DIV_W, 26, divider counter width; must satisfy 2^DIV_W > max(SLOW_DIV, MED_DIV)
DEB_CYCLES, 500_000, cycles a synchronised input must be stable before it is accepted (≥1)
CNT_W, 16, width of the issued-cycle counter

Ports:
clk  in  1  board clock; sole clock domain
rst  in  1  synchronous reset, active-high
step_btn_n  in  1  raw push button, active-low, asynchronous
mode  in  2  00 step, 01 slow, 10 medium, 11 full
brk_en  in  1  breakpoint enable
brk_addr  in  ADDR_W  breakpoint address
pc_addr  in  ADDR_W  current CPU program counter
cnt_clr  in  1  synchronous clear of `cycle_cnt`
cpu_ce  out  1  CPU clock enable, one `clk` cycle wide per CPU step
halted  out  1  high while stopped at a breakpoint
btn_db  out  1  debounced button level, active-high = pressed
cycle_cnt  out  CNT_W  number of `cpu_ce` pulses issued (wraps)

Behaviour:
Reset (rst=1 at a `clk` edge):
- Outputs: `cpu_ce`=0, `halted`=0, `btn_db`=0, `cycle_cnt`=0.
- Internal: divider=0, skip flag=0, synchroniser=released, debounce counter=0.
- State = STEP if `mode`=00, else RUN.
- Reset mid-operation wins over every other event in that cycle.

Button path:
- 2-FF synchroniser, then debounce: `btn_db` changes only after the synchronised level differs from `btn_db` for DEB_CYCLES consecutive cycles; any bounce restarts the count.
- `press` = one-cycle pulse on the `btn_db` 0→1 edge, registered, so it appears the cycle after `btn_db` rises.
- Latency from a clean raw edge to `btn_db` = 2 + DEB_CYCLES cycles.

Divider:
- Counts 0..DIV-1 for the current mode; `tick` when count = DIV-1, then wraps to 0.
- DIV=1 gives `tick` every cycle.
- Divider is cleared whenever `mode` differs from its registered previous value, so the first `tick` after a change comes a full DIV cycles later.

States:
STEP:
- `cpu_ce` = `press`.
- Leave to RUN when `mode`≠00.
RUN:
- `cpu_ce` = `tick` in slow/medium, 1 every cycle in full.
- Breakpoint: if `brk_en` and `pc_addr`==`brk_addr` and skip=0, go to BRK in the same cycle and suppress `cpu_ce` that cycle.
- `mode`=00 → STEP.
BRK:
- `halted`=1, `cpu_ce`=0.
- `press` → issue exactly one `cpu_ce`, set skip=1, go to RUN (or STEP if `mode`=00).
- Deasserting `brk_en` also returns to RUN, with no extra pulse.
- A `mode` change while in BRK does not leave BRK.

Skip flag:
- Cleared when `pc_addr`≠`brk_addr`, so a breakpoint on a tight self-loop re-fires only after the PC leaves and returns.
- Breakpoints are not checked in STEP.

Outputs:
- `cpu_ce`, `halted` and `cycle_cnt` are registered; the decision made in cycle N appears in cycle N+1.
- `cycle_cnt` increments on each `cpu_ce`=1 and wraps from 2^CNT_W-1 to 0.
- `cnt_clr` has priority over an increment in the same cycle.

Decomposition:
Package `cpu_clk_pkg` holds:
- mode encodings MODE_STEP/MODE_SLOW/MODE_MED/MODE_FULL;
- state enum S_STEP/S_RUN/S_BRK.

One sub-module, `btn_sync_debounce` (parameter DEB_CYCLES; ports clk, rst, in_n, level, press), containing the synchroniser, debounce counter and edge pulse. Divider, FSM and counter stay in the top.

Test Plan:
Simulation parameters: DEB_CYCLES=4, SLOW_DIV=10, MED_DIV=3, CNT_W=4.
- Reset then `mode`=00, press held 20 cycles with 2-cycle bounces first → exactly one `cpu_ce` pulse; `btn_db` rises 6 cycles after the last bounce; `cycle_cnt`=1.
- `mode`=01 for 100 cycles → exactly 10 `cpu_ce` pulses, 10 cycles apart; switch to 10 mid-count → first pulse 3 cycles after the switch, then every 3.
- `mode`=11 for 20 cycles → `cpu_ce`=1 continuously; `cycle_cnt` wraps 15→0 and reads 4 after 20 pulses.
- `mode`=11, `brk_en`=1, `brk_addr`=0x005, `pc_addr` increments per `cpu_ce` from 0 → halt with `pc_addr`=0x005, `halted`=1, `cpu_ce`=0; one press → exactly one pulse, `halted`=0, no re-halt at 0x005.
- Halted, `pc_addr` held at 0x005 (self-loop) → press resumes; with `pc_addr` still 0x005 no re-halt; after `pc_addr`→0x006→0x005 → halts again.
- `rst` asserted while in BRK with `cnt_clr`=0 → next cycle `halted`=0, `cpu_ce`=0, `cycle_cnt`=0; `cnt_clr` together with `cpu_ce` → `cycle_cnt`=0.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller: mode selector values
// and the sequencing state machine states.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_MED  = 2'b10;
  localparam logic [1:0] MODE_FULL = 2'b11;

  typedef enum logic [1:0] {
    S_STEP = 2'b00,
    S_RUN  = 2'b01,
    S_BRK  = 2'b10
  } state_t;

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser and debouncer for an active-low push button; produces
// an active-high debounced level and a registered one-cycle press pulse.
module btn_sync_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with the output restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= ~in_n;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: step / slow / medium / full rates, PC breakpoint
// with halt and single-step resume, and a wrapping issued-cycle counter.
//   state  | meaning
//   S_STEP | one cpu_ce per debounced button press
//   S_RUN  | free-running at the rate selected by mode, breakpoint armed
//   S_BRK  | stopped at breakpoint; a press issues one cpu_ce and resumes
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int SLOW_DIV   = 50_000_000,
  parameter int MED_DIV    = 5_000_000,
  parameter int DIV_W      = 26,
  parameter int DEB_CYCLES = 500_000,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_btn_n,
  input  logic [1:0]        mode,
  input  logic              brk_en,
  input  logic [ADDR_W-1:0] brk_addr,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              cnt_clr,
  output logic              cpu_ce,
  output logic              halted,
  output logic              btn_db,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] MED_LAST  = DIV_W'(MED_DIV - 1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d, div_last;
  logic [1:0]         mode_prev_q;
  logic               mode_chg, tick, press, brk_hit;
  logic               skip_q, skip_d;
  logic               ce_q, ce_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  btn_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .in_n  (step_btn_n),
    .level (btn_db),
    .press (press)
  );

  // A mode change restarts the divider so the new rate gets a full period.
  always_comb begin
    mode_chg = (mode != mode_prev_q);
    div_last = (mode == MODE_SLOW) ? SLOW_LAST : MED_LAST;
    tick     = !mode_chg && (div_q == div_last);
    div_d    = (mode_chg || tick) ? '0 : div_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ce_d    = 1'b0;
    brk_hit = (pc_addr == brk_addr);
    if (!brk_hit) skip_d = 1'b0;
    case (state_q)
      S_STEP: begin
        ce_d = press;
        if (mode != MODE_STEP) state_d = S_RUN;
      end
      S_RUN: begin
        if (mode == MODE_STEP) begin
          state_d = S_STEP;
        end else if (brk_en && brk_hit && !skip_q) begin
          state_d = S_BRK;
        end else begin
          ce_d = (mode == MODE_FULL) ? 1'b1 : tick;
        end
      end
      S_BRK: begin
        if (press) begin
          ce_d    = 1'b1;
          skip_d  = 1'b1;
          state_d = (mode == MODE_STEP) ? S_STEP : S_RUN;
        end else if (!brk_en) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
    halted_d = (state_d == S_BRK);
    if (cnt_clr)   cnt_d = '0;
    else if (ce_q) cnt_d = cnt_q + 1'b1;
    else           cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (mode == MODE_STEP) ? S_STEP : S_RUN;
      div_q       <= '0;
      mode_prev_q <= mode;
      skip_q      <= 1'b0;
      ce_q        <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      mode_prev_q <= mode;
      skip_q      <= skip_d;
      ce_q        <= ce_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_ce    = ce_q;
  assign halted    = halted_q;
  assign cycle_cnt = cnt_q;

endmodule
